// File: rtl/pose_integrator_pkg.sv
// Shared fixed-point constants and FSM encoding for the pose integrator.
// Sign-magnitude words: MSB is the sign, Q_WIDTH fractional bits.
package pose_integrator_pkg;
  localparam int N_WIDTH  = 17;
  localparam int Q_WIDTH  = 8;
  localparam int DT_SHIFT = 6;
  // round(pi * 2^Q_WIDTH), which is 804 at Q8
  localparam int PI_Q     = (3217 * (1 << Q_WIDTH)) / 1024;
  localparam int TWO_PI_Q = 2 * PI_Q;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADD_X = 3'd1,
    S_ADD_Y = 3'd2,
    S_ADD_T = 3'd3,
    S_WRAP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;
endpackage

// File: rtl/pose_integrator_sm_add_sat.sv
// Combinational sign-magnitude adder; same-sign sums saturate at the largest
// magnitude, and a zero result always comes out as +0.
module sm_add_sat #(
  parameter int N = 17
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_sum
);
  localparam int M = N - 1;

  logic [M:0]   w_add;
  logic [M-1:0] w_mag;
  logic         w_sgn;

  always_comb begin
    w_add = {1'b0, i_a[M-1:0]} + {1'b0, i_b[M-1:0]};
    w_mag = '0;
    w_sgn = 1'b0;
    if (i_a[M] == i_b[M]) begin
      w_mag = w_add[M] ? '1 : w_add[M-1:0];
      w_sgn = i_a[M];
    end else if (i_a[M-1:0] >= i_b[M-1:0]) begin
      w_mag = i_a[M-1:0] - i_b[M-1:0];
      w_sgn = i_a[M];
    end else begin
      w_mag = i_b[M-1:0] - i_a[M-1:0];
      w_sgn = i_b[M];
    end
    o_sum = {w_sgn & (|w_mag), w_mag};
  end
endmodule

// File: rtl/pose_integrator.sv
// Odometry pose integrator: one shared saturating adder, one axis per cycle.
// Define POSE_INTEGRATOR_THETA_WRAP_EN to wrap THETA into [-pi, pi] after each update.
module pose_integrator
  import pose_integrator_pkg::*;
#(
  parameter int N_WIDTH  = pose_integrator_pkg::N_WIDTH,
  parameter int DT_SHIFT = pose_integrator_pkg::DT_SHIFT
) (
  input  logic               POSE_INTEGRATOR_CLOCK_50,
  input  logic               POSE_INTEGRATOR_RESET_InHigh,
  input  logic               POSE_INTEGRATOR_SAMPLE_InHigh,
  input  logic               POSE_INTEGRATOR_LOAD_InHigh,
  input  logic [N_WIDTH-1:0] POSE_INTEGRATOR_VX_InBus,
  input  logic [N_WIDTH-1:0] POSE_INTEGRATOR_VY_InBus,
  input  logic [N_WIDTH-1:0] POSE_INTEGRATOR_WZ_InBus,
  input  logic [N_WIDTH-1:0] POSE_INTEGRATOR_INITX_InBus,
  input  logic [N_WIDTH-1:0] POSE_INTEGRATOR_INITY_InBus,
  input  logic [N_WIDTH-1:0] POSE_INTEGRATOR_INITTHETA_InBus,
  output logic [N_WIDTH-1:0] POSE_INTEGRATOR_X_OutBus,
  output logic [N_WIDTH-1:0] POSE_INTEGRATOR_Y_OutBus,
  output logic [N_WIDTH-1:0] POSE_INTEGRATOR_THETA_OutBus,
  output logic               POSE_INTEGRATOR_BUSY_OutHigh,
  output logic               POSE_INTEGRATOR_VALID_OutHigh,
  output logic               POSE_INTEGRATOR_OVERRUN_OutHigh
);
  localparam int M = N_WIDTH - 1;

  state_t             r_state;
  logic [N_WIDTH-1:0] r_vx, r_vy, r_wz;
  logic [N_WIDTH-1:0] r_x, r_y, r_th;
  logic               r_busy, r_valid, r_ovr;

  logic [N_WIDTH-1:0] w_acc, w_vel, w_inc, w_sum;
  logic [M-1:0]       w_inc_mag;

  // Operand mux for the shared adder; THETA is the default lane.
  always_comb begin
    w_acc = r_th;
    w_vel = r_wz;
    case (r_state)
      S_ADD_X: begin w_acc = r_x; w_vel = r_vx; end
      S_ADD_Y: begin w_acc = r_y; w_vel = r_vy; end
      default: begin w_acc = r_th; w_vel = r_wz; end
    endcase
  end

  assign w_inc_mag = w_vel[M-1:0] >> DT_SHIFT;
  assign w_inc     = {w_vel[M] & (|w_inc_mag), w_inc_mag};

  sm_add_sat #(.N(N_WIDTH)) u_add (
    .i_a  (w_acc),
    .i_b  (w_inc),
    .o_sum(w_sum)
  );

`ifdef POSE_INTEGRATOR_THETA_WRAP_EN
  logic [M-1:0] w_wrap_mag;
  assign w_wrap_mag = M'(TWO_PI_Q) - r_th[M-1:0];
`endif

  always_ff @(posedge POSE_INTEGRATOR_CLOCK_50 or posedge POSE_INTEGRATOR_RESET_InHigh) begin
    if (POSE_INTEGRATOR_RESET_InHigh) begin
      r_state <= S_IDLE;
      r_vx    <= '0;
      r_vy    <= '0;
      r_wz    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_th    <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (POSE_INTEGRATOR_LOAD_InHigh) begin
      // Load aborts any in-flight update and drops a coincident SAMPLE.
      r_state <= S_IDLE;
      r_x     <= POSE_INTEGRATOR_INITX_InBus;
      r_y     <= POSE_INTEGRATOR_INITY_InBus;
      r_th    <= POSE_INTEGRATOR_INITTHETA_InBus;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (POSE_INTEGRATOR_SAMPLE_InHigh) begin
            r_vx    <= POSE_INTEGRATOR_VX_InBus;
            r_vy    <= POSE_INTEGRATOR_VY_InBus;
            r_wz    <= POSE_INTEGRATOR_WZ_InBus;
            r_busy  <= 1'b1;
            r_state <= S_ADD_X;
          end
        end
        S_ADD_X: begin
          r_x     <= w_sum;
          r_state <= S_ADD_Y;
        end
        S_ADD_Y: begin
          r_y     <= w_sum;
          r_state <= S_ADD_T;
        end
        S_ADD_T: begin
          r_th    <= w_sum;
`ifdef POSE_INTEGRATOR_THETA_WRAP_EN
          r_state <= S_WRAP;
`else
          r_state <= S_DONE;
          r_valid <= 1'b1;
`endif
        end
`ifdef POSE_INTEGRATOR_THETA_WRAP_EN
        S_WRAP: begin
          if (r_th[M-1:0] > M'(PI_Q))
            r_th <= {~r_th[M] & (|w_wrap_mag), w_wrap_mag};
          r_state <= S_DONE;
          r_valid <= 1'b1;
        end
`endif
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (POSE_INTEGRATOR_SAMPLE_InHigh && (r_state != S_IDLE))
        r_ovr <= 1'b1;
    end
  end

  assign POSE_INTEGRATOR_X_OutBus        = r_x;
  assign POSE_INTEGRATOR_Y_OutBus        = r_y;
  assign POSE_INTEGRATOR_THETA_OutBus    = r_th;
  assign POSE_INTEGRATOR_BUSY_OutHigh    = r_busy;
  assign POSE_INTEGRATOR_VALID_OutHigh   = r_valid;
  assign POSE_INTEGRATOR_OVERRUN_OutHigh = r_ovr;
endmodule
